// File: rtl/rf80386_icache.sv
// rf80386 two-bank direct-mapped instruction cache.
// Returns a 16-byte window at csip every cycle; fills missing lines over the bus.
module rf80386_icache #(
  parameter int          IDXW     = 6,
  parameter logic [4:0]  RTY_WAIT = 5'd8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  csip,
  input  logic         inv_i,
  output logic [127:0] ibundle,
  output logic         ihit,
  output logic         cyc_o,
  output logic         stb_o,
  output logic [31:0]  adr_o,
  input  logic         ack_i,
  input  logic         rty_i,
  input  logic [127:0] dat_i
);

  localparam int NL = 1 << IDXW;
  localparam int TW = 27 - IDXW;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} st_t;

  st_t          r_state;
  logic         r_bus;
  logic         r_kill;
  logic [4:0]   r_cnt;
  logic [27:0]  r_fadr;

  logic [TW-1:0] r_tag0 [NL];
  logic [TW-1:0] r_tag1 [NL];
  logic [127:0]  r_dat0 [NL];
  logic [127:0]  r_dat1 [NL];
  logic [NL-1:0] r_val0;
  logic [NL-1:0] r_val1;

  logic [27:0]     w_l0, w_l1, w_le, w_lo;
  logic [IDXW-1:0] w_ie, w_io, w_fi;
  logic [TW-1:0]   w_ft;
  logic            w_he, w_ho, w_hit0, w_hit1, w_wr;
  logic [127:0]    w_line0, w_line1;
  logic [255:0]    w_win;

  // L0 and L1 always land in opposite banks: pick the even and odd line
  assign w_l0 = csip[31:4];
  assign w_l1 = w_l0 + 28'd1;
  assign w_le = w_l0[0] ? w_l1 : w_l0;
  assign w_lo = w_l0[0] ? w_l0 : w_l1;
  assign w_ie = w_le[IDXW:1];
  assign w_io = w_lo[IDXW:1];

  assign w_he = r_val0[w_ie] && (r_tag0[w_ie] == w_le[27:IDXW+1]);
  assign w_ho = r_val1[w_io] && (r_tag1[w_io] == w_lo[27:IDXW+1]);

  assign w_hit0  = w_l0[0] ? w_ho : w_he;
  assign w_hit1  = w_l0[0] ? w_he : w_ho;
  assign w_line0 = w_l0[0] ? r_dat1[w_io] : r_dat0[w_ie];
  assign w_line1 = w_l0[0] ? r_dat0[w_ie] : r_dat1[w_io];

  assign w_win   = {w_line1, w_line0} >> {csip[3:0], 3'b000};
  assign ibundle = w_win[127:0];
  assign ihit    = !rst_i && w_hit0 && w_hit1;

  assign cyc_o = r_bus;
  assign stb_o = r_bus;
  assign adr_o = {r_fadr, 4'h0};

  assign w_wr = (r_state == S_WAIT) && ack_i;
  assign w_fi = r_fadr[IDXW:1];
  assign w_ft = r_fadr[27:IDXW+1];

  always_ff @(posedge clk_i) begin
    if (w_wr && !rst_i) begin
      if (r_fadr[0]) begin
        r_tag1[w_fi] <= w_ft;
        r_dat1[w_fi] <= dat_i;
      end else begin
        r_tag0[w_fi] <= w_ft;
        r_dat0[w_fi] <= dat_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || inv_i) begin
      r_val0 <= '0;
      r_val1 <= '0;
    end else if (w_wr && !r_kill) begin
      if (r_fadr[0]) r_val1[w_fi] <= 1'b1;
      else           r_val0[w_fi] <= 1'b1;
    end
  end

  // Retry hold-off counts the REQ cycle, so stb stays low RTY_WAIT cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_bus   <= 1'b0;
      r_kill  <= 1'b0;
      r_cnt   <= 5'd0;
      r_fadr  <= 28'd0;
    end else begin
      if (inv_i && r_state != S_IDLE) r_kill <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (!w_hit0) begin
            r_fadr  <= w_l0;
            r_state <= S_REQ;
          end else if (!w_hit1) begin
            r_fadr  <= w_l1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_bus   <= 1'b1;
          r_state <= S_WAIT;
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        S_WAIT: begin
          if (ack_i) begin
            r_bus   <= 1'b0;
            r_kill  <= 1'b0;
            r_state <= S_IDLE;
          end else if (rty_i) begin
            r_bus   <= 1'b0;
            r_cnt   <= RTY_WAIT;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt <= 5'd2) r_state <= S_REQ;
        end
      endcase
    end
  end

endmodule
